pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central sequencing and hazard controller for the 5-stage MIPS pipeline (fetch/decode/execute/memory/writeback).
- Owns PC advance and redirect selection, the fetch-warm bubble required by the synchronous instruction ROM, pipeline flushes on jump/taken-beq, load-use stalls, and execute-stage operand forwarding selects.
- Keeps saturating retired/stall counters for the 7-segment debug display.

Parameters:
- CNT_W, 16, width of the retired and stall counters.

Ports:
- clock  in  1  pipeline clock (divided board clock)
- reset  in  1  asynchronous, active-low reset (0 = reset)
- run  in  1  1 = pipeline may advance, 0 = pause
- decode_ir  in  32  instruction in decode stage
- execute_ir  in  32  instruction in execute stage
- memory_ir  in  32  instruction in memory stage
- wback_ir  in  32  instruction in writeback stage
- jump_req  in  1  execute stage holds j
- beq_taken  in  1  execute stage holds beq with equal operands
- pc_en  out  1  PC register load enable
- pc_sel  out  2  0 = PC+1, 1 = jump target, 2 = PC_execute+offset
- fd_en  out  1  load decode_ir from ROM output
- fd_flush  out  1  load decode_ir with 0 (NOP)
- dx_en  out  1  load execute_ir from decode_ir
- dx_flush  out  1  load execute_ir with 0
- fwd_a  out  2  execute rs source: 0 = regfile, 1 = memory-stage ALU result, 2 = writeback data
- fwd_b  out  2  execute rt source, same encoding as fwd_a
- state  out  2  FSM state, for the debug LEDs
- retired_cnt  out  CNT_W  instructions retired
- stall_cnt  out  CNT_W  load-use stall cycles

Behaviour:
- Instruction classes:
  - R-type: opcode 000000 with funct 100000 (add) or 100010 (sub).
  - Others by opcode: addi 001000, lw 100011, sw 101011, beq 000100, j 000010.
  - Any other word, including 0, is a NOP.
- Register usage:
  - Writes: R-type writes rd [15:11]; addi and lw write rt [20:16]; no other class writes.
  - Reads: R-type, beq and sw read rs [25:21] and rt [20:16]; addi and lw read rs only.
  - Register 0 never matches for hazard or forwarding.
- FSM states: HOLD = 0, WARM = 1, RUN = 2, REDIR = 3. State is registered; all control outputs are combinational from state and the IR inputs.
- Reset: asynchronous, takes effect immediately regardless of clock.
  - state = HOLD, counters = 0.
  - In HOLD: pc_en = 0, fd_en = 0, dx_en = 0, fd_flush = 1, dx_flush = 1, pc_sel = 0, fwd_a = 0, fwd_b = 0.
- HOLD:
  - Outputs as for reset.
  - run = 1 moves to WARM on the next edge.
- WARM (one cycle, absorbs the 1-cycle ROM latency):
  - pc_en = 1, pc_sel = 0, fd_flush = 1, dx_en = 1.
  - Always moves to RUN.
- RUN, evaluated in priority order:
  - Priority 1, run = 0 (pause): all enables 0, no flushes, counters frozen, stay in RUN. Resuming needs no warm cycle because PC is unchanged.
  - Priority 2, jump_req = 1 (wins over beq_taken): pc_en = 1, pc_sel = 1, fd_flush = 1, dx_flush = 1. Moves to REDIR.
  - Priority 3, beq_taken = 1: same as priority 2 but pc_sel = 2. Moves to REDIR.
  - Priority 4, load-use: execute_ir is lw and its dest matches a register read by decode_ir. Then pc_en = 0, fd_en = 0, dx_flush = 1, stall_cnt += 1. Stay in RUN.
  - Priority 5, otherwise: pc_en = 1, pc_sel = 0, fd_en = 1, dx_en = 1.
  - A redirect in the same cycle as a load-use hazard is a redirect only; stall_cnt does not increment.
- REDIR:
  - pc_en = 1, pc_sel = 0, fd_flush = 1, dx_en = 1.
  - Moves to RUN. A redirect is never taken from REDIR, since execute holds the bubble.
- Forwarding, per execute source register (rs for fwd_a, rt for fwd_b):
  - 1 if memory_ir writes that register and memory_ir is not lw.
  - Else 2 if wback_ir writes that register.
  - Else 0.
  - A memory-stage lw can never match, because the load-use stall prevents it.
  - Forwarding is valid in every state; HOLD forces 0.
- Counters:
  - retired_cnt += 1 on each edge where the state is not HOLD, run = 1, and wback_ir is a non-NOP.
  - Both counters saturate at all ones and never wrap.

Test Plan:
- Reset, hold run = 0 for 3 cycles, then run = 1 -> outputs at reset values; state sequence HOLD, WARM, RUN; pc_en = 1 from the WARM cycle on.
- execute_ir = lw $2,0($1) (0x8C220000), decode_ir = add $3,$2,$4 (0x00441820) -> exactly one cycle with pc_en = 0, fd_en = 0, dx_flush = 1; stall_cnt = 1; next cycle normal advance.
- memory_ir = add $3,$1,$2 (0x00221820), wback_ir = addi $3,$0,5 (0x20030005), execute_ir = sub $5,$3,$3 (0x00632822) -> fwd_a = 1, fwd_b = 1. Repeat with memory_ir = 0 -> fwd_a = 2, fwd_b = 2.
- jump_req = 1 and beq_taken = 1 together in RUN, with a load-use hazard also present -> pc_sel = 1, fd_flush = 1, dx_flush = 1; next state REDIR then RUN; stall_cnt unchanged.
- run dropped to 0 for 4 cycles mid-RUN -> all enables 0, no flushes, counters frozen, state stays RUN; advance resumes the cycle after run = 1.
- Preload retired_cnt near all ones (force), keep wback_ir non-NOP -> saturates at 0xFFFF. Assert reset mid-stall -> immediate HOLD outputs and zeroed counters without a clock edge.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath and its sequencing/hazard controller.
// The datapath side drives instruction words and redirect requests; the controller answers with enables and selects.
interface pipe_ctrl_if #(parameter int CNT_W = 16);
  logic             run;
  logic [31:0]      decode_ir;
  logic [31:0]      execute_ir;
  logic [31:0]      memory_ir;
  logic [31:0]      wback_ir;
  logic             jump_req;
  logic             beq_taken;
  logic             pc_en;
  logic [1:0]       pc_sel;
  logic             fd_en;
  logic             fd_flush;
  logic             dx_en;
  logic             dx_flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [1:0]       state;
  logic [CNT_W-1:0] retired_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output run, decode_ir, execute_ir, memory_ir, wback_ir, jump_req, beq_taken,
    input  pc_en, pc_sel, fd_en, fd_flush, dx_en, dx_flush, fwd_a, fwd_b, state,
           retired_cnt, stall_cnt
  );

  modport slave (
    input  run, decode_ir, execute_ir, memory_ir, wback_ir, jump_req, beq_taken,
    output pc_en, pc_sel, fd_en, fd_flush, dx_en, dx_flush, fwd_a, fwd_b, state,
           retired_cnt, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Sequencing and hazard control for the 5-stage MIPS pipeline: PC advance/redirect,
// ROM warm-up bubble, flushes, load-use stalls, execute forwarding and debug counters.

// One execute source operand: pick memory-stage ALU result, writeback data or regfile.
module pipe_ctrl_fwd (
  input  logic       en_i,
  input  logic [4:0] src_i,
  input  logic [4:0] mem_dst_i,
  input  logic       mem_lw_i,
  input  logic [4:0] wb_dst_i,
  output logic [1:0] sel_o
);
  always_comb begin
    sel_o = 2'd0;
    if (en_i && src_i != 5'd0) begin
      if (!mem_lw_i && mem_dst_i == src_i) sel_o = 2'd1;
      else if (wb_dst_i == src_i)          sel_o = 2'd2;
    end
  end
endmodule

module pipe_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic       clock,
  input  logic       reset,
  pipe_ctrl_if.slave bus
);
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;

  typedef enum logic [1:0] {HOLD = 2'd0, WARM = 2'd1, RUN = 2'd2, REDIR = 2'd3} state_t;

  function automatic logic is_r(input logic [31:0] ir);
    return ir[31:26] == OP_R && (ir[5:0] == F_ADD || ir[5:0] == F_SUB);
  endfunction

  function automatic logic is_lw(input logic [31:0] ir);
    return ir[31:26] == OP_LW;
  endfunction

  // Destination register, or 0 when the class writes nothing (0 never matches).
  function automatic logic [4:0] dst(input logic [31:0] ir);
    if (is_r(ir)) return ir[15:11];
    if (ir[31:26] == OP_ADDI || ir[31:26] == OP_LW) return ir[20:16];
    return 5'd0;
  endfunction

  function automatic logic rd_rs(input logic [31:0] ir);
    return is_r(ir) || ir[31:26] == OP_BEQ || ir[31:26] == OP_SW ||
           ir[31:26] == OP_ADDI || ir[31:26] == OP_LW;
  endfunction

  function automatic logic rd_rt(input logic [31:0] ir);
    return is_r(ir) || ir[31:26] == OP_BEQ || ir[31:26] == OP_SW;
  endfunction

  function automatic logic is_nop(input logic [31:0] ir);
    return !(rd_rs(ir) || ir[31:26] == OP_J);
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             load_use, stall_inc;
  logic [4:0]       ex_dst;

  assign ex_dst   = dst(bus.execute_ir);
  assign load_use = is_lw(bus.execute_ir) && ex_dst != 5'd0 &&
                    ((rd_rs(bus.decode_ir) && bus.decode_ir[25:21] == ex_dst) ||
                     (rd_rt(bus.decode_ir) && bus.decode_ir[20:16] == ex_dst));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= HOLD;
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bus.pc_en    = 1'b0;
    bus.pc_sel   = 2'd0;
    bus.fd_en    = 1'b0;
    bus.fd_flush = 1'b0;
    bus.dx_en    = 1'b0;
    bus.dx_flush = 1'b0;
    stall_inc    = 1'b0;
    unique case (state_q)
      HOLD: begin
        bus.fd_flush = 1'b1;
        bus.dx_flush = 1'b1;
        if (bus.run) state_d = WARM;
      end
      // WARM and REDIR both push one bubble while the ROM catches up with the new PC.
      WARM, REDIR: begin
        bus.pc_en    = 1'b1;
        bus.fd_flush = 1'b1;
        bus.dx_en    = 1'b1;
        state_d      = RUN;
      end
      RUN: begin
        if (!bus.run) begin
          state_d = RUN;
        end else if (bus.jump_req || bus.beq_taken) begin
          bus.pc_en    = 1'b1;
          bus.pc_sel   = bus.jump_req ? 2'd1 : 2'd2;
          bus.fd_flush = 1'b1;
          bus.dx_flush = 1'b1;
          state_d      = REDIR;
        end else if (load_use) begin
          bus.dx_flush = 1'b1;
          stall_inc    = 1'b1;
        end else begin
          bus.pc_en = 1'b1;
          bus.fd_en = 1'b1;
          bus.dx_en = 1'b1;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_comb begin
    retired_d = retired_q;
    stall_d   = stall_q;
    if (state_q != HOLD && bus.run && !is_nop(bus.wback_ir) && retired_q != '1)
      retired_d = retired_q + CNT_W'(1);
    if (stall_inc && stall_q != '1)
      stall_d = stall_q + CNT_W'(1);
  end

  // Lane 0 serves rs (fwd_a), lane 1 serves rt (fwd_b).
  logic [1:0][4:0] ex_src;
  logic [1:0][1:0] fwd_sel;
  assign ex_src = {bus.execute_ir[20:16], bus.execute_ir[25:21]};

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_fwd
      pipe_ctrl_fwd u_fwd (
        .en_i      (state_q != HOLD),
        .src_i     (ex_src[g]),
        .mem_dst_i (dst(bus.memory_ir)),
        .mem_lw_i  (is_lw(bus.memory_ir)),
        .wb_dst_i  (dst(bus.wback_ir)),
        .sel_o     (fwd_sel[g])
      );
    end
  endgenerate

  assign bus.fwd_a       = fwd_sel[0];
  assign bus.fwd_b       = fwd_sel[1];
  assign bus.state       = state_q;
  assign bus.retired_cnt = retired_q;
  assign bus.stall_cnt   = stall_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a driver pushes hand-computed expectations, a monitor pops and checks them.
// A 3-bit-counter twin shares the stimulus so saturation is reached in a few cycles.
module tb_pipe_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  pipe_ctrl_if #(.CNT_W(16)) bus ();
  pipe_ctrl_if #(.CNT_W(3))  bus_s ();

  pipe_ctrl #(.CNT_W(16)) dut (.clock(clock), .reset(reset), .bus(bus.slave));
  pipe_ctrl #(.CNT_W(3))  dut_s (.clock(clock), .reset(reset), .bus(bus_s.slave));

  assign bus_s.run        = bus.run;
  assign bus_s.decode_ir  = bus.decode_ir;
  assign bus_s.execute_ir = bus.execute_ir;
  assign bus_s.memory_ir  = bus.memory_ir;
  assign bus_s.wback_ir   = bus.wback_ir;
  assign bus_s.jump_req   = bus.jump_req;
  assign bus_s.beq_taken  = bus.beq_taken;

  // {pc_en, pc_sel[1:0], fd_en, fd_flush, dx_en, dx_flush}
  localparam logic [6:0] C_HOLD  = 7'b0_00_0_1_0_1;
  localparam logic [6:0] C_WARM  = 7'b1_00_0_1_1_0;
  localparam logic [6:0] C_ADV   = 7'b1_00_1_0_1_0;
  localparam logic [6:0] C_STALL = 7'b0_00_0_0_0_1;
  localparam logic [6:0] C_PAUSE = 7'b0_00_0_0_0_0;
  localparam logic [6:0] C_JMP   = 7'b1_01_0_1_0_1;
  localparam logic [6:0] C_BEQ   = 7'b1_10_0_1_0_1;

  localparam logic [31:0] LW21  = 32'h8C220000; // lw  $2,0($1)
  localparam logic [31:0] ADD3  = 32'h00441820; // add $3,$2,$4
  localparam logic [31:0] MADD  = 32'h00221820; // add $3,$1,$2
  localparam logic [31:0] ADDI3 = 32'h20030005; // addi $3,$0,5
  localparam logic [31:0] ADDI4 = 32'h20040001; // addi $4,$0,1
  localparam logic [31:0] ADDI2 = 32'h20020005; // addi $2,$0,5
  localparam logic [31:0] SUB33 = 32'h00632822; // sub $5,$3,$3
  localparam logic [31:0] SUB34 = 32'h00642822; // sub $5,$3,$4
  localparam logic [31:0] LW3   = 32'h8C030000; // lw  $3,0($0)

  typedef struct {
    string      nm;
    logic [6:0] ctl;
    logic [1:0] fa, fb, st;
    int         ret, stl;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic step(input string nm, input logic rn, input logic r,
                      input logic [31:0] d, input logic [31:0] e, input logic [31:0] m,
                      input logic [31:0] w, input logic j, input logic b,
                      input logic [6:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                      input logic [1:0] st, input int ret, input int stl);
    exp_t x;
    @(negedge clock);
    reset = rn; bus.run = r;
    bus.decode_ir = d; bus.execute_ir = e; bus.memory_ir = m; bus.wback_ir = w;
    bus.jump_req = j; bus.beq_taken = b;
    x.nm = nm; x.ctl = ctl; x.fa = fa; x.fb = fb; x.st = st; x.ret = ret; x.stl = stl;
    q.push_back(x);
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (q.size() > 0) begin
        exp_t x;
        logic [6:0] act;
        int sret, sstl;
        x    = q.pop_front();
        act  = {bus.pc_en, bus.pc_sel, bus.fd_en, bus.fd_flush, bus.dx_en, bus.dx_flush};
        sret = (x.ret > 7) ? 7 : x.ret;
        sstl = (x.stl > 7) ? 7 : x.stl;
        total++;
        if (act !== x.ctl || bus.fwd_a !== x.fa || bus.fwd_b !== x.fb || bus.state !== x.st ||
            bus.retired_cnt !== 16'(x.ret) || bus.stall_cnt !== 16'(x.stl) ||
            bus_s.retired_cnt !== 3'(sret) || bus_s.stall_cnt !== 3'(sstl)) begin
          bad++;
          $display("FAIL %s: got ctl=%b fa=%0d fb=%0d st=%0d ret=%0d stl=%0d sret=%0d sstl=%0d; want ctl=%b fa=%0d fb=%0d st=%0d ret=%0d stl=%0d sret=%0d sstl=%0d",
                   x.nm, act, bus.fwd_a, bus.fwd_b, bus.state, bus.retired_cnt, bus.stall_cnt,
                   bus_s.retired_cnt, bus_s.stall_cnt,
                   x.ctl, x.fa, x.fb, x.st, x.ret, x.stl, sret, sstl);
        end
      end
    end
  end

  initial begin
    bus.run = 1'b0; bus.decode_ir = '0; bus.execute_ir = '0; bus.memory_ir = '0;
    bus.wback_ir = '0; bus.jump_req = 1'b0; bus.beq_taken = 1'b0;

    // Reset and HOLD: forwarding would match but is forced to 0; no retiring in HOLD.
    step("rst",      0, 0, 0, SUB33, MADD, ADDI3, 0, 0, C_HOLD, 0, 0, 0, 0, 0);
    repeat (3)
      step("hold",   1, 0, 0, SUB33, MADD, ADDI3, 0, 0, C_HOLD, 0, 0, 0, 0, 0);
    step("hold_go",  1, 1, 0, SUB33, MADD, ADDI3, 0, 0, C_HOLD, 0, 0, 0, 0, 0);
    step("warm",     1, 1, 0, 0, 0, 0, 0, 0, C_WARM, 0, 0, 1, 0, 0);
    step("run0",     1, 1, 0, 0, 0, 0, 0, 0, C_ADV,  0, 0, 2, 0, 0);

    step("lu",       1, 1, ADD3, LW21, 0, 0, 0, 0, C_STALL, 0, 0, 2, 0, 0);
    step("lu_after", 1, 1, ADD3, 0,    0, 0, 0, 0, C_ADV,   0, 0, 2, 0, 1);

    step("fwd1",     1, 1, 0, SUB33, MADD, ADDI3, 0, 0, C_ADV, 1, 1, 2, 0, 1);
    step("fwd2",     1, 1, 0, SUB33, 0,    ADDI3, 0, 0, C_ADV, 2, 2, 2, 1, 1);
    step("fwd_lw",   1, 1, 0, SUB33, LW3,  ADDI3, 0, 0, C_ADV, 2, 2, 2, 2, 1);
    step("fwd_mix",  1, 1, 0, SUB34, MADD, ADDI4, 0, 0, C_ADV, 1, 2, 2, 3, 1);
    step("fwd_none", 1, 1, 0, SUB33, 0,    0,     0, 0, C_ADV, 0, 0, 2, 4, 1);

    step("redir",    1, 1, ADD3, LW21, 0, 0, 1, 1, C_JMP,  0, 0, 2, 4, 1);
    step("redir2",   1, 1, 0, 0, 0, 0, 0, 0, C_WARM, 0, 0, 3, 4, 1);
    step("redir3",   1, 1, 0, 0, 0, 0, 0, 0, C_ADV,  0, 0, 2, 4, 1);
    step("beq",      1, 1, 0, 0, 0, 0, 0, 1, C_BEQ,  0, 0, 2, 4, 1);
    step("redir_ign",1, 1, 0, 0, 0, 0, 1, 0, C_WARM, 0, 0, 3, 4, 1);
    step("after_ign",1, 1, 0, 0, 0, 0, 0, 0, C_ADV,  0, 0, 2, 4, 1);

    // Pause beats a pending jump and a load-use hazard; counters stay frozen.
    repeat (4)
      step("pause",  1, 0, ADD3, LW21, 0, ADDI2, 1, 0, C_PAUSE, 0, 2, 2, 4, 1);
    step("resume",   1, 1, 0, 0, 0, 0, 0, 0, C_ADV, 0, 0, 2, 4, 1);

    for (int i = 0; i < 6; i++)
      step("retire", 1, 1, 0, 0, 0, ADDI3, 0, 0, C_ADV, 0, 0, 2, 4 + i, 1);

    step("stall2",   1, 1, ADD3, LW21, 0, 0, 0, 0, C_STALL, 0, 0, 2, 10, 1);
    step("stall3",   1, 1, ADD3, LW21, 0, 0, 0, 0, C_STALL, 0, 0, 2, 10, 2);
    // Reset dropped at a falling edge: HOLD outputs must appear before any rising edge.
    step("areset",   0, 1, ADD3, LW21, 0, 0, 0, 0, C_HOLD, 0, 0, 0, 0, 0);
    step("post",     1, 0, 0, 0, 0, 0, 0, 0, C_HOLD, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clock);
    #4;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
